// File: rtl/multi_reg_mem_responder.sv
// Multi-register burst responder (LDM/STM style) over a 256x32 word RAM.
// Define ALIGN_CHECK_EN to fault misaligned bursts and suppress their data movement.
module multi_reg_mem_responder (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        beat_valid_i,
   input  logic        beat_write_i,
   input  logic        beat_last_i,
   input  logic [31:0] base_addr_i,
   input  logic [2:0]  reg_idx_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rd_write_en_o,
   output logic [2:0]  rd_idx_o,
   output logic [31:0] rdata_o,
   output logic        base_wb_en_o,
   output logic [31:0] base_wb_data_o,
   output logic [3:0]  beat_count_o,
   output logic        fault_o
);

   // state  | meaning
   // S_IDLE | waiting for beat 0; base taken from base_addr_i
   // S_XFER | mid-burst; beat n uses latched base + 4*n
   // S_WB   | one-cycle base writeback, beats refused
   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [3:0]  count_q, count_d;
   logic        blk_fault_q, blk_fault_d;
   logic        rd_en_q, wb_en_q, fault_q;
   logic [2:0]  rd_idx_q;
   logic [31:0] rdata_q, wb_data_q;
   logic [31:0] mem [256];

   logic        accept, is_last, misalign, beat_fault, mem_we, load_acc;
   logic [7:0]  word_idx;

`ifdef ALIGN_CHECK_EN
   assign misalign = (base_addr_i[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      count_d     = count_q;
      blk_fault_d = blk_fault_q;
      ready_o     = (state_q != S_WB);
      accept      = beat_valid_i && ready_o;
      is_last     = beat_last_i || (count_q == 4'd7);
      beat_fault  = (state_q == S_IDLE) ? misalign : blk_fault_q;
      // Low two address bits never carry into [9:2] since the offset is a word multiple.
      word_idx    = ((state_q == S_IDLE) ? base_addr_i[9:2] : base_q[9:2]) + {4'd0, count_q};
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               base_d      = base_addr_i;
               count_d     = 4'd1;
               blk_fault_d = misalign;
               state_d     = is_last ? S_WB : S_XFER;
            end
         end
         S_XFER: begin
            if (accept) begin
               count_d = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
               if (is_last) state_d = S_WB;
            end
         end
         S_WB: begin
            count_d     = 4'd0;
            blk_fault_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      mem_we   = accept && beat_write_i && !beat_fault && !reset_i;
      load_acc = accept && !beat_write_i && !beat_fault;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[word_idx] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         base_q      <= 32'd0;
         count_q     <= 4'd0;
         blk_fault_q <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_idx_q    <= 3'd0;
         rdata_q     <= 32'd0;
         wb_en_q     <= 1'b0;
         wb_data_q   <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         count_q     <= count_d;
         blk_fault_q <= blk_fault_d;
         rd_en_q     <= load_acc;
         if (load_acc) begin
            rd_idx_q <= reg_idx_i;
            rdata_q  <= mem[word_idx];
         end
         wb_en_q <= (state_d == S_WB);
         if (state_d == S_WB) wb_data_q <= base_d + {26'd0, count_d, 2'b00};
         fault_q <= accept && (state_q == S_IDLE) && misalign;
      end
   end

   assign rd_write_en_o  = rd_en_q;
   assign rd_idx_o       = rd_idx_q;
   assign rdata_o        = rdata_q;
   assign base_wb_en_o   = wb_en_q;
   assign base_wb_data_o = wb_data_q;
   assign beat_count_o   = count_q;
   assign fault_o        = fault_q;

endmodule

// File: tb/tb_multi_reg_mem_responder.sv
// Bench for multi_reg_mem_responder: directed burst table, reset/abort sequences and
// random bursts against a word-array memory model.
module tb_multi_reg_mem_responder;

`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, valid, write, last;
   logic [31:0] base_addr, wdata;
   logic [2:0]  ridx;
   logic        ready, rd_en, wb_en, fault;
   logic [2:0]  rd_idx;
   logic [31:0] rdata, wb_data;
   logic [3:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ram_m [256];
   bit          known_m [256];

   multi_reg_mem_responder dut (
      .clk_i(clk), .reset_i(reset), .beat_valid_i(valid), .beat_write_i(write),
      .beat_last_i(last), .base_addr_i(base_addr), .reg_idx_i(ridx), .wdata_i(wdata),
      .ready_o(ready), .rd_write_en_o(rd_en), .rd_idx_o(rd_idx), .rdata_o(rdata),
      .base_wb_en_o(wb_en), .base_wb_data_o(wb_data), .beat_count_o(count), .fault_o(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] widx(input logic [31:0] base, input int n);
      logic [31:0] a;
      a = base + 32'(4 * n);
      return a[9:2];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic do_burst(input logic [7:0] wr_mask, input logic [31:0] base, input int n,
                           input bit use_last, input bit gaps, input bit poke_wb,
                           input logic [31:0] exp_wb);
      bit flt;
      flt = ALIGN && (base[1:0] != 2'b00);
      for (int i = 0; i < n; i++) begin
         logic [7:0]  ix;
         logic [2:0]  r;
         bit          is_ld, kn;
         logic [31:0] ed;
         ix    = widx(base, i);
         r     = 3'($urandom);
         is_ld = !wr_mask[i];
         valid = 1'b1;
         write = wr_mask[i];
         last  = use_last && (i == n - 1);
         base_addr = (i == 0) ? base : $urandom;
         ridx  = r;
         wdata = $urandom;
         chk("ready_in_beat", 32'(ready), 32'd1);
         chk("count_before_beat", 32'(count), 32'(i));
         kn = known_m[ix];
         ed = ram_m[ix];
         if (!is_ld && !flt) begin
            ram_m[ix]   = wdata;
            known_m[ix] = 1'b1;
         end
         tick();
         valid = 1'b0;
         chk("fault", 32'(fault), (i == 0 && flt) ? 32'd1 : 32'd0);
         if (is_ld && !flt) begin
            chk("rd_en_pulse", 32'(rd_en), 32'd1);
            chk("rd_idx", 32'(rd_idx), 32'(r));
            if (kn) chk("rdata", rdata, ed);
         end else begin
            chk("rd_en_quiet", 32'(rd_en), 32'd0);
         end
         if (gaps && i < n - 1 && $urandom_range(0, 2) == 0) begin
            tick();
            chk("rd_en_gap", 32'(rd_en), 32'd0);
            chk("count_gap", 32'(count), 32'(i + 1));
            chk("ready_gap", 32'(ready), 32'd1);
         end
      end
      chk("ready_wb", 32'(ready), 32'd0);
      chk("wb_en", 32'(wb_en), 32'd1);
      chk("wb_data", wb_data, exp_wb);
      chk("count_wb", 32'(count), 32'(n));
      if (poke_wb) begin
         valid = 1'b1; write = 1'b1; last = 1'b1;
         base_addr = $urandom; wdata = 32'hDEAD_BEEF;
      end
      tick();
      valid = 1'b0; write = 1'b0; last = 1'b0;
      chk("wb_en_drop", 32'(wb_en), 32'd0);
      chk("ready_after_wb", 32'(ready), 32'd1);
      chk("count_cleared", 32'(count), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  wr;
      logic [31:0] base;
      int          n;
      bit          use_last;
      logic [31:0] exp_wb;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{8'hFF, 32'h0000_0100, 3, 1'b1, 32'h0000_010C};
      vecs[1] = '{8'h00, 32'h0000_0100, 2, 1'b1, 32'h0000_0108};
      vecs[2] = '{8'hFF, 32'h0000_0400, 8, 1'b0, 32'h0000_0420};
      vecs[3] = '{8'hFF, 32'h0000_03F8, 4, 1'b1, 32'h0000_0408};
      vecs[4] = '{8'h00, 32'h0000_03F8, 4, 1'b1, 32'h0000_0408};
      vecs[5] = '{8'hFF, 32'hFFFF_FFFC, 2, 1'b1, 32'h0000_0004};
      vecs[6] = '{8'h00, 32'h0000_0000, 2, 1'b1, 32'h0000_0008};
      vecs[7] = '{8'h15, 32'h0000_0200, 5, 1'b1, 32'h0000_0214};
      vecs[8] = '{8'hFF, 32'h0000_0102, 1, 1'b1, 32'h0000_0106};
      vecs[9] = '{8'h00, 32'h0000_0100, 1, 1'b1, 32'h0000_0104};

      reset = 1'b1; valid = 1'b0; write = 1'b0; last = 1'b0;
      base_addr = '0; wdata = '0; ridx = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_rd_idx", 32'(rd_idx), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset = 1'b0;

      for (int v = 0; v < 10; v++)
         do_burst(vecs[v].wr, vecs[v].base, vecs[v].n, vecs[v].use_last, 1'b0, 1'b1, vecs[v].exp_wb);

      // Reset on the second beat of a load burst.
      valid = 1'b1; write = 1'b0; last = 1'b0; base_addr = 32'h100; ridx = 3'd6;
      tick();
      chk("abort_ld_beat0_rd_en", 32'(rd_en), 32'd1);
      chk("abort_ld_beat0_rdata", rdata, ram_m[8'h40]);
      reset = 1'b1; base_addr = 32'h0; ridx = 3'd2;
      tick();
      reset = 1'b0; valid = 1'b0;
      chk("abort_ld_rd_en", 32'(rd_en), 32'd0);
      chk("abort_ld_wb_en", 32'(wb_en), 32'd0);
      chk("abort_ld_ready", 32'(ready), 32'd1);
      chk("abort_ld_count", 32'(count), 32'd0);
      tick();
      chk("abort_ld_wb_en2", 32'(wb_en), 32'd0);
      chk("abort_ld_rd_en2", 32'(rd_en), 32'd0);

      // Reset on the second beat of a store burst: that beat must not reach RAM.
      do_burst(8'hFF, 32'h300, 2, 1'b1, 1'b0, 1'b0, 32'h308);
      valid = 1'b1; write = 1'b1; last = 1'b0; base_addr = 32'h300; wdata = 32'h1111_2222;
      ram_m[8'hC0] = 32'h1111_2222;
      tick();
      reset = 1'b1; wdata = 32'h3333_4444;
      tick();
      reset = 1'b0; valid = 1'b0; write = 1'b0;
      chk("abort_st_wb_en", 32'(wb_en), 32'd0);
      chk("abort_st_ready", 32'(ready), 32'd1);
      do_burst(8'h00, 32'h300, 2, 1'b1, 1'b0, 1'b0, 32'h308);

      for (int k = 0; k < 60; k++) begin
         logic [31:0] b;
         int          n;
         bit          ul;
         b = {22'($urandom), 8'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 7) == 0) b[1:0] = 2'($urandom_range(1, 3));
         n  = $urandom_range(1, 8);
         ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         do_burst(8'($urandom), b, n, ul, 1'b1, 1'($urandom_range(0, 1)), b + 32'(4 * n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
